// File: rtl/game_ctrl.sv
// Game sequencer for the bird-and-pipes LED game: button conditioning, IDLE/PLAY/OVER
// state machine, collision detect, pipe-scroll tick divider and a saturating BCD score.
module game_ctrl #(
    parameter int ROWS      = 8,
    parameter int TICK_BITS = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            key_raw,
    input  logic [ROWS-1:0] bird,
    input  logic [ROWS-1:0] pipe_col,
    input  logic            pipe_pass,
    output logic            ongoing,
    output logic            gameOver,
    output logic            press,
    output logic            tick,
    output logic [3:0]      score_ones,
    output logic [3:0]      score_tens
);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [TICK_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]           ones_q, ones_d, tens_q, tens_d;
    logic                 press_rise, collision, tick_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
        end
    end

    assign press_rise = sync2_q & ~prev_q;
    // Empty bird vector means the bird flew off the display; treated as a crash.
    assign collision  = (|(bird & pipe_col)) || (bird == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        ones_d   = ones_q;
        tens_d   = tens_q;
        ongoing  = 1'b0;
        gameOver = 1'b0;
        tick_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_rise) begin
                    state_d = PLAY;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                end
            end
            PLAY: begin
                ongoing = 1'b1;
                tick_d  = (cnt_q == '1);
                if (collision) begin
                    state_d = OVER;
                end else begin
                    cnt_d = cnt_q + TICK_BITS'(1);
                    if (pipe_pass && !(ones_q == 4'd9 && tens_q == 4'd9)) begin
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end
                end
            end
            OVER: begin
                ongoing  = 1'b1;
                gameOver = 1'b1;
                if (press_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign press      = sync2_q;
    assign tick       = tick_d;
    assign score_ones = ones_q;
    assign score_tens = tens_q;

endmodule
